// File: rtl/keypad_scanner_if.sv
// Keypad pin and digit-output bundle: the scanner drives rows and results, the keypad side drives columns.
interface keypad_scanner_if;
  logic [2:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_number;
  logic       key_held;

  modport master (input col, output row, output key_valid, output key_number, output key_held);
  modport slave  (output col, input row, input key_valid, input key_number, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: rotating one-hot row drive, per-scan hit collection, debounced press/release FSM.
// key_valid pulses one clock after the accepting scan_done; there is no backpressure, and the consumer must take the strobe.
module keypad_scanner #(
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      acc_hits_q, acc_hits_d;
  logic [3:0]      acc_digit_q, acc_digit_d;
  logic [3:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_number_q, key_number_d;
  logic            key_held_q, key_held_d;

  logic            last_dwell, scan_done, cnt_hits_target;
  logic [2:0]      hits;
  logic [1:0]      row_idx, hit_col, row_n, tot_hits;
  logic [3:0]      row_digit, scan_digit;
  logic            do_accept;
  logic [3:0]      accept_digit;

  always_comb begin
    last_dwell = (dwell_q == DW'(SCAN_CYCLES - 1));
    scan_done  = last_dwell && row_q[3];
    // Row 3 only carries '0' in the middle column; '*' and '#' are ignored.
    hits       = kp.col & (row_q[3] ? 3'b010 : 3'b111);

    row_idx = row_q[1] ? 2'd1 : row_q[2] ? 2'd2 : row_q[3] ? 2'd3 : 2'd0;
    hit_col = hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd0;
    case (hits)
      3'b000:                 row_n = 2'd0;
      3'b001, 3'b010, 3'b100: row_n = 2'd1;
      default:                row_n = 2'd2;
    endcase
    row_digit = (row_idx == 2'd3) ? 4'd0
              : ({2'b00, row_idx} * 4'd3) + {2'b00, hit_col} + 4'd1;

    // Hit count saturates at 2, which is all MULTI needs.
    if (acc_hits_q == 2'd0)  tot_hits = row_n;
    else if (row_n == 2'd0)  tot_hits = acc_hits_q;
    else                     tot_hits = 2'd2;
    scan_digit = (acc_hits_q == 2'd0 && row_n != 2'd0) ? row_digit : acc_digit_q;
    cnt_hits_target = (int'(cnt_q) + 1 == DEBOUNCE);
  end

  always_comb begin
    row_d        = row_q;
    dwell_d      = dwell_q;
    acc_hits_d   = acc_hits_q;
    acc_digit_d  = acc_digit_q;
    state_d      = state_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    key_valid_d  = 1'b0;
    key_number_d = key_number_q;
    key_held_d   = key_held_q;
    do_accept    = 1'b0;
    accept_digit = cand_q;

    if (last_dwell) begin
      dwell_d     = '0;
      row_d       = {row_q[2:0], row_q[3]};
      acc_hits_d  = scan_done ? 2'd0 : tot_hits;
      acc_digit_d = scan_done ? 4'd0 : scan_digit;
    end else begin
      dwell_d = dwell_q + DW'(1);
    end

    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (tot_hits == 2'd1) begin
            cand_d = scan_digit;
            cnt_d  = CW'(1);
            if (DEBOUNCE == 1) begin
              do_accept    = 1'b1;
              accept_digit = scan_digit;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tot_hits == 2'd1 && scan_digit == cand_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_hits_target) do_accept = 1'b1;
          end else if (tot_hits == 2'd1) begin
            cand_d = scan_digit;
            cnt_d  = CW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (tot_hits == 2'd0) begin
            cnt_d = CW'(1);
            if (DEBOUNCE == 1) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (tot_hits == 2'd0) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_hits_target) begin
              state_d    = ST_IDLE;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (do_accept) begin
      state_d      = ST_PRESSED;
      key_number_d = accept_digit;
      key_valid_d  = 1'b1;
      key_held_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= 4'b0001;
      dwell_q      <= '0;
      acc_hits_q   <= 2'd0;
      acc_digit_q  <= 4'd0;
      cand_q       <= 4'd0;
      cnt_q        <= '0;
      key_valid_q  <= 1'b0;
      key_number_q <= 4'd0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      acc_hits_q   <= acc_hits_d;
      acc_digit_q  <= acc_digit_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_valid_q  <= key_valid_d;
      key_number_q <= key_number_d;
      key_held_q   <= key_held_d;
    end
  end

  assign kp.row        = row_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_number = key_number_q;
  assign kp.key_held   = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (SCAN_CYCLES=2, DEBOUNCE=2): keypad matrix model, vector table, scoreboard of accepted digits.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pressed = '0;
  logic [2:0]  col_m;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        prev_kv = 1'b0;
  logic [3:0]  exp_row;
  logic [3:0]  sb[$];

  typedef struct {
    logic [11:0] mask;
    int          scans;
    bit          acc;
    logic [3:0]  digit;
    bit          held;
  } vec_t;
  vec_t vecs[21];

  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_CYCLES(2), .DEBOUNCE(2)) dut (.clk(clk), .reset(reset), .kp(kp));

  always #5 clk = ~clk;

  // Pressed key at (r,c) is bit r*3+c; it closes onto column c only while row r is driven.
  always_comb begin
    col_m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && kp.row[r]) col_m[c] = 1'b1;
  end
  assign kp.col = col_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_row = 4'b0001 << ((cyc / 2) % 4);
      check("row_rotation", kp.row, exp_row);
      if (kp.key_valid) begin
        check("kv_back_to_back", prev_kv, 0);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL kv_unexpected: key_number=%0d with nothing expected", kp.key_number);
        end else begin
          check("key_number", kp.key_number, sb.pop_front());
        end
      end
    end
    prev_kv = kp.key_valid;
  end

  initial begin
    vecs[0]  = '{12'h400, 2, 1'b1, 4'd0, 1'b1};
    vecs[1]  = '{12'h000, 2, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{12'h200, 3, 1'b0, 4'd0, 1'b0};
    vecs[3]  = '{12'h800, 3, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{12'hA00, 2, 1'b0, 4'd0, 1'b0};
    vecs[5]  = '{12'h040, 1, 1'b0, 4'd0, 1'b0};
    vecs[6]  = '{12'h000, 1, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{12'h040, 1, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{12'h040, 2, 1'b1, 4'd7, 1'b1};
    vecs[9]  = '{12'h000, 2, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{12'h101, 5, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{12'h001, 2, 1'b1, 4'd1, 1'b1};
    vecs[12] = '{12'h000, 2, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{12'h002, 1, 1'b0, 4'd0, 1'b0};
    vecs[14] = '{12'h004, 2, 1'b1, 4'd3, 1'b1};
    vecs[15] = '{12'h000, 2, 1'b0, 4'd0, 1'b0};
    vecs[16] = '{12'h008, 2, 1'b1, 4'd4, 1'b1};
    vecs[17] = '{12'h108, 2, 1'b0, 4'd0, 1'b1};
    vecs[18] = '{12'h000, 1, 1'b0, 4'd0, 1'b1};
    vecs[19] = '{12'h008, 1, 1'b0, 4'd0, 1'b1};
    vecs[20] = '{12'h000, 2, 1'b0, 4'd0, 1'b0};

    tick(2);
    check("rst_row", kp.row, 4'b0001);
    check("rst_key_valid", kp.key_valid, 0);
    check("rst_key_number", kp.key_number, 0);
    check("rst_key_held", kp.key_held, 0);
    reset = 1'b0;

    // '5' held from the first post-reset clock: accept exactly 1 clk after the 2nd scan_done (edge 16).
    pressed = 12'h010;
    sb.push_back(4'd5);
    tick(15);
    check("five_kv_early", kp.key_valid, 0);
    tick(1);
    check("five_kv", kp.key_valid, 1);
    check("five_number", kp.key_number, 5);
    check("five_held", kp.key_held, 1);
    tick(1);
    check("five_kv_one_cycle", kp.key_valid, 0);
    tick(7 + 7 * 8);
    pressed = 12'h000;
    tick(15);
    check("five_held_before_release", kp.key_held, 1);
    tick(1);
    check("five_released", kp.key_held, 0);

    foreach (vecs[i]) begin
      if (vecs[i].acc) sb.push_back(vecs[i].digit);
      pressed = vecs[i].mask;
      tick(vecs[i].scans * 8);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_held", i), kp.key_held, vecs[i].held);
      check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
      sb.delete();
    end

    // Reset in the middle of debouncing '3': state is abandoned and the scan restarts at row0.
    pressed = 12'h004;
    tick(8 + 3);
    reset = 1'b1;
    tick(1);
    check("mid_rst_row", kp.row, 4'b0001);
    check("mid_rst_key_valid", kp.key_valid, 0);
    check("mid_rst_key_number", kp.key_number, 0);
    check("mid_rst_key_held", kp.key_held, 0);
    reset = 1'b0;
    sb.push_back(4'd3);
    tick(15);
    check("post_rst_kv_early", kp.key_valid, 0);
    tick(1);
    check("post_rst_kv", kp.key_valid, 1);
    check("post_rst_number", kp.key_number, 3);
    pressed = 12'h000;
    tick(16);
    @(negedge clk);
    #1;
    check("post_rst_released", kp.key_held, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
